// File: rtl/gaussian3x3_stream_if.sv
// Pixel stream bundle (AXI-Stream style) carrying one signed pixel per transfer.
// TLAST is only driven on the producing side; the consuming modport does not see it.
interface gaussian3x3_stream_if #(
    parameter int PIXEL_BIT_WIDTH = 16
);
    logic signed [PIXEL_BIT_WIDTH-1:0] TDATA;
    logic                              TVALID;
    logic                              TREADY;
    logic                              TLAST;

    modport master (output TDATA, output TVALID, output TLAST, input TREADY);
    modport slave  (input TDATA, input TVALID, output TREADY);
endinterface

// File: rtl/gaussian3x3_stream.sv
// Streaming 3x3 Gaussian blur [1 2 1; 2 4 2; 1 2 1]/16 over a raster frame,
// emitting only valid-region pixels through a single registered output stage.
module gaussian3x3_stream #(
    parameter int PIXEL_BIT_WIDTH  = 16,
    parameter int IMG_ROWS         = 48,
    parameter int IMG_COLS         = 48,
    parameter int IMG_ROW_BITWIDTH = 10,
    parameter int IMG_COL_BITWIDTH = 10
) (
    input  logic clk,
    input  logic reset,
    gaussian3x3_stream_if.slave  pixel_in,
    gaussian3x3_stream_if.master pixel_out
);
    localparam int PW = PIXEL_BIT_WIDTH;
    localparam int SW = PIXEL_BIT_WIDTH + 4;
    localparam int CW = $clog2(IMG_COLS);
    localparam logic [IMG_ROW_BITWIDTH-1:0] ROW_LAST = IMG_ROW_BITWIDTH'(IMG_ROWS - 1);
    localparam logic [IMG_COL_BITWIDTH-1:0] COL_LAST = IMG_COL_BITWIDTH'(IMG_COLS - 1);
    localparam logic [IMG_ROW_BITWIDTH-1:0] ROW_TWO  = IMG_ROW_BITWIDTH'(2);
    localparam logic [IMG_COL_BITWIDTH-1:0] COL_TWO  = IMG_COL_BITWIDTH'(2);
    localparam logic [IMG_ROW_BITWIDTH-1:0] ROW_ONE  = IMG_ROW_BITWIDTH'(1);
    localparam logic [IMG_COL_BITWIDTH-1:0] COL_ONE  = IMG_COL_BITWIDTH'(1);

    function automatic logic signed [SW-1:0] ext(input logic signed [PW-1:0] p);
        return SW'(p);
    endfunction

    // Arithmetic shift by 4 then truncation; bits [PW+3:4] are exactly floor(sum/16).
    function automatic logic signed [PW-1:0] floor_div16(input logic signed [SW-1:0] s);
        return s[PW+3:4];
    endfunction

    logic [IMG_ROW_BITWIDTH-1:0] row_p0;
    logic [IMG_COL_BITWIDTH-1:0] col_p0;
    logic signed [PW-1:0] lb0 [IMG_COLS];
    logic signed [PW-1:0] lb1 [IMG_COLS];
    logic signed [PW-1:0] win_p0 [3][3];
    logic signed [PW-1:0] data_p1;
    logic                 last_p1;
    logic                 vld_p1;

    logic                 in_ready;
    logic                 xfer;
    logic                 produce;
    logic                 last_pix;
    logic [CW-1:0]        col_idx;
    logic signed [PW-1:0] din;
    logic signed [PW-1:0] lb0_rd;
    logic signed [PW-1:0] lb1_rd;
    logic signed [SW-1:0] sum_p0;

    assign in_ready = reset & (~vld_p1 | pixel_out.TREADY);
    assign xfer     = pixel_in.TVALID & in_ready;
    assign col_idx  = col_p0[CW-1:0];
    assign din      = pixel_in.TDATA;
    assign lb0_rd   = lb0[col_idx];
    assign lb1_rd   = lb1[col_idx];
    assign last_pix = (row_p0 == ROW_LAST) && (col_p0 == COL_LAST);
    assign produce  = xfer && (row_p0 >= ROW_TWO) && (col_p0 >= COL_TWO);

    // Sum over the window as it will look after this transfer's shift:
    // left = old column 1, centre = old column 2, right = incoming column.
    always_comb begin
        sum_p0 = ext(win_p0[0][1]) + (ext(win_p0[0][2]) <<< 1) + ext(lb1_rd)
               + (ext(win_p0[1][1]) <<< 1) + (ext(win_p0[1][2]) <<< 2) + (ext(lb0_rd) <<< 1)
               + ext(win_p0[2][1]) + (ext(win_p0[2][2]) <<< 1) + ext(din);
    end

    // ---- stage p0: raster position, line buffers, window ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_p0 <= '0;
            col_p0 <= '0;
        end else if (xfer) begin
            if (col_p0 == COL_LAST) begin
                col_p0 <= '0;
                row_p0 <= (row_p0 == ROW_LAST) ? '0 : row_p0 + ROW_ONE;
            end else begin
                col_p0 <= col_p0 + COL_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (xfer) begin
            lb1[col_idx] <= lb0_rd;
            lb0[col_idx] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    win_p0[i][j] <= '0;
        end else if (xfer) begin
            for (int i = 0; i < 3; i++) begin
                win_p0[i][0] <= win_p0[i][1];
                win_p0[i][1] <= win_p0[i][2];
            end
            win_p0[0][2] <= lb1_rd;
            win_p0[1][2] <= lb0_rd;
            win_p0[2][2] <= din;
        end
    end

    // ---- stage p1: registered output, held until downstream accepts ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_p1 <= '0;
            last_p1 <= 1'b0;
            vld_p1  <= 1'b0;
        end else if (produce) begin
            data_p1 <= floor_div16(sum_p0);
            last_p1 <= last_pix;
            vld_p1  <= 1'b1;
        end else if (pixel_out.TREADY) begin
            vld_p1  <= 1'b0;
        end
    end

    assign pixel_in.TREADY  = in_ready;
    assign pixel_out.TDATA  = data_p1;
    assign pixel_out.TLAST  = last_p1;
    assign pixel_out.TVALID = vld_p1;
endmodule

// File: tb/tb_gaussian3x3_stream.sv
// Directed bench for gaussian3x3_stream: whole frames with closed-form expectations,
// an impulse table, backpressure, stall, back-to-back frames and mid-frame reset.
module tb_gaussian3x3_stream;
    localparam int PW   = 16;
    localparam int ROWS = 48;
    localparam int COLS = 48;
    localparam int OC   = COLS - 2;
    localparam int NOUT = (ROWS - 2) * (COLS - 2);
    localparam int K_CONST = 0, K_RAMP = 1, K_IMP = 2;

    typedef struct {
        int val;
        int cr;
        int cc;
        int exp;
    } imp_vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    gaussian3x3_stream_if #(.PIXEL_BIT_WIDTH(PW)) in_if ();
    gaussian3x3_stream_if #(.PIXEL_BIT_WIDTH(PW)) out_if ();

    gaussian3x3_stream #(
        .PIXEL_BIT_WIDTH(PW), .IMG_ROWS(ROWS), .IMG_COLS(COLS),
        .IMG_ROW_BITWIDTH(10), .IMG_COL_BITWIDTH(10)
    ) dut (
        .clk(clk), .reset(reset), .pixel_in(in_if), .pixel_out(out_if)
    );

    int passed = 0;
    int total  = 0;
    int cap_data [2*NOUT];
    bit cap_last [2*NOUT];
    int cap_n = 0;
    bit rand_rdy = 1'b0;
    bit rdy_hold = 1'b1;
    bit rand_vld = 1'b0;
    imp_vec_t imp_tab [16];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: actual %0d expected %0d", name, act, exp);
    endtask

    initial begin : ready_drv
        out_if.TREADY = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_if.TREADY = rand_rdy ? ($urandom_range(1, 0) == 1) : rdy_hold;
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (out_if.TVALID && out_if.TREADY && cap_n < 2*NOUT) begin
                cap_data[cap_n] = int'(out_if.TDATA);
                cap_last[cap_n] = out_if.TLAST;
                cap_n++;
            end
        end
    end

    function automatic int pix(input int kind, input int val, input int r, input int c);
        if (kind == K_CONST) return val;
        if (kind == K_RAMP) return r * COLS + c;
        return (r == 10 && c == 10) ? val : 0;
    endfunction

    // Called and returns at posedge+1; drives npix pixels of a frame in raster order.
    task automatic send_frame(input int kind, input int val, input int npix, input bit lat_chk);
        int r, c, waitc;
        bit done;
        for (int k = 0; k < npix; k++) begin
            r = k / COLS;
            c = k % COLS;
            if (rand_vld) begin
                while ($urandom_range(1, 0) == 0) begin
                    in_if.TVALID = 1'b0;
                    @(posedge clk);
                    #1;
                end
            end
            in_if.TDATA  = PW'(pix(kind, val, r, c));
            in_if.TVALID = 1'b1;
            done  = 1'b0;
            waitc = 0;
            while (!done) begin
                @(negedge clk);
                done = in_if.TREADY && in_if.TVALID;
                @(posedge clk);
                #1;
                waitc++;
                if (!done && waitc > 3000) begin
                    check("send_timeout", k, -1);
                    in_if.TVALID = 1'b0;
                    return;
                end
            end
            if (lat_chk && r == 2 && c == 1) check("pre_first_valid", int'(out_if.TVALID), 0);
            if (lat_chk && r == 2 && c == 2) begin
                check("first_out_valid", int'(out_if.TVALID), 1);
                check("first_out_data", int'(out_if.TDATA), 100);
            end
        end
        in_if.TVALID = 1'b0;
    endtask

    task automatic wait_out(input int n);
        int k = 0;
        while (cap_n < n && k < 20000) begin
            @(posedge clk);
            k++;
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input string tag, input int kind, input int val, input int base);
        int errs = 0, lasts = 0, lastpos = -1, i, j, e;
        for (int k = 0; k < NOUT; k++) begin
            i = k / OC;
            j = k % OC;
            e = (kind == K_CONST) ? val : (i + 1) * COLS + (j + 1);
            if (cap_data[base + k] != e) errs++;
            if (cap_last[base + k]) begin
                lasts++;
                lastpos = k;
            end
        end
        check({tag, "_data_mismatches"}, errs, 0);
        check({tag, "_tlast_count"}, lasts, 1);
        check({tag, "_tlast_pos"}, lastpos, NOUT - 1);
    endtask

    initial begin : main
        int idx, sum, nz, nonincr, bad, hd, hl, kk;
        int imp_vals [3];
        imp_tab[0]  = '{16, 10, 10, 4};
        imp_tab[1]  = '{16,  9, 10, 2};
        imp_tab[2]  = '{16, 11, 10, 2};
        imp_tab[3]  = '{16, 10,  9, 2};
        imp_tab[4]  = '{16, 10, 11, 2};
        imp_tab[5]  = '{16,  9,  9, 1};
        imp_tab[6]  = '{16, 11, 11, 1};
        imp_tab[7]  = '{16,  9, 11, 1};
        imp_tab[8]  = '{16, 11,  9, 1};
        imp_tab[9]  = '{16,  8, 10, 0};
        imp_tab[10] = '{16, 10, 12, 0};
        imp_tab[11] = '{-1, 10, 10, -1};
        imp_tab[12] = '{-1,  9,  9, -1};
        imp_tab[13] = '{-1, 12, 10, 0};
        imp_tab[14] = '{ 1, 10, 10, 0};
        imp_tab[15] = '{ 1,  9, 10, 0};
        imp_vals[0] = 16; imp_vals[1] = -1; imp_vals[2] = 1;

        reset = 1'b0;
        in_if.TVALID = 1'b0;
        in_if.TDATA  = '0;
        in_if.TLAST  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", int'(out_if.TVALID), 0);
        check("rst_out_data", int'(out_if.TDATA), 0);
        check("rst_out_last", int'(out_if.TLAST), 0);
        check("rst_in_ready", int'(in_if.TREADY), 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", int'(in_if.TREADY), 1);

        cap_n = 0;
        send_frame(K_CONST, 100, ROWS * COLS, 1'b1);
        wait_out(NOUT);
        check("const_count", cap_n, NOUT);
        check_frame("const", K_CONST, 100, 0);

        cap_n = 0;
        send_frame(K_RAMP, 0, ROWS * COLS, 1'b0);
        wait_out(NOUT);
        check("ramp_count", cap_n, NOUT);
        check_frame("ramp", K_RAMP, 0, 0);
        check("ramp_first", cap_data[0], 49);
        check("ramp_last", cap_data[NOUT-1], 2254);
        nonincr = 0;
        for (int k = 1; k < NOUT; k++) if (cap_data[k] <= cap_data[k-1]) nonincr++;
        check("ramp_nonincreasing", nonincr, 0);

        for (int v = 0; v < 3; v++) begin
            cap_n = 0;
            send_frame(K_IMP, imp_vals[v], ROWS * COLS, 1'b0);
            wait_out(NOUT);
            check($sformatf("imp%0d_count", imp_vals[v]), cap_n, NOUT);
            for (int t = 0; t < 16; t++) begin
                if (imp_tab[t].val == imp_vals[v]) begin
                    idx = (imp_tab[t].cr - 1) * OC + (imp_tab[t].cc - 1);
                    check($sformatf("imp%0d_at_%0d_%0d", imp_tab[t].val, imp_tab[t].cr, imp_tab[t].cc),
                          cap_data[idx], imp_tab[t].exp);
                end
            end
            if (imp_vals[v] == 16) begin
                sum = 0;
                nz  = 0;
                for (int k = 0; k < NOUT; k++) begin
                    sum += cap_data[k];
                    if (cap_data[k] != 0) nz++;
                end
                check("imp16_sum", sum, 16);
                check("imp16_nonzero", nz, 9);
            end
        end

        cap_n = 0;
        rand_rdy = 1'b1;
        rand_vld = 1'b1;
        send_frame(K_RAMP, 0, ROWS * COLS, 1'b0);
        wait_out(NOUT);
        rand_rdy = 1'b0;
        rand_vld = 1'b0;
        rdy_hold = 1'b1;
        check("rand_count", cap_n, NOUT);
        check_frame("rand", K_RAMP, 0, 0);

        cap_n = 0;
        fork
            send_frame(K_RAMP, 0, ROWS * COLS, 1'b0);
            begin
                kk = 0;
                while (cap_n < 100 && kk < 5000) begin
                    @(posedge clk);
                    kk++;
                end
                rdy_hold = 1'b0;
                repeat (2) @(posedge clk);
                @(negedge clk);
                check("stall_valid", int'(out_if.TVALID), 1);
                hd  = int'(out_if.TDATA);
                hl  = int'(out_if.TLAST);
                bad = 0;
                repeat (200) begin
                    @(negedge clk);
                    if (!out_if.TVALID || int'(out_if.TDATA) != hd || int'(out_if.TLAST) != hl || in_if.TREADY)
                        bad++;
                end
                check("stall_violations", bad, 0);
                rdy_hold = 1'b1;
            end
        join
        wait_out(NOUT);
        check("stall_count", cap_n, NOUT);
        check_frame("stall", K_RAMP, 0, 0);

        cap_n = 0;
        send_frame(K_RAMP, 0, ROWS * COLS, 1'b0);
        send_frame(K_CONST, 100, ROWS * COLS, 1'b0);
        wait_out(2 * NOUT);
        check("b2b_count", cap_n, 2 * NOUT);
        check_frame("b2b_ramp", K_RAMP, 0, 0);
        check_frame("b2b_const", K_CONST, 100, NOUT);

        cap_n = 0;
        send_frame(K_RAMP, 0, 1000, 1'b0);
        check("pre_reset_pending", int'(out_if.TVALID), 1);
        reset = 1'b0;
        #1;
        check("midrst_out_valid", int'(out_if.TVALID), 0);
        check("midrst_in_ready", int'(in_if.TREADY), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        cap_n = 0;
        send_frame(K_RAMP, 0, ROWS * COLS, 1'b0);
        wait_out(NOUT);
        check("post_reset_count", cap_n, NOUT);
        check_frame("post_reset", K_RAMP, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
